t_merge_4to2: RTL

// - Stream fan-in operator for the tandem page pipeline: merges four AXI-Stream inputs into two outputs.
//   - Output_1 is fed by Input_1 and Input_2.
//   - Output_2 is fed by Input_3 and Input_4.
// - Each output has its own arbiter and a registered output slot, so both lanes run independently.
// - The block sits downstream of the t_1 broadcast operator and recombines its duplicated streams.

---
 rtl/t_merge_4to2.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/t_merge_4to2.sv
// -----------------------------------------------------------------------------
// t_merge_4to2 -- four-into-two AXI-Stream fan-in for the tandem page pipeline.
//
// Recombines the duplicated streams produced by the upstream t_1 broadcast
// operator. There are two independent lanes:
//   lane 1 : Input_1, Input_2 -> Output_1
//   lane 2 : Input_3, Input_4 -> Output_2
// Each lane has its own arbiter and a one-entry registered output slot. A lane
// can accept a new beat in the same cycle its slot drains, so each lane
// sustains one beat per cycle. Latency is one cycle from input acceptance to
// output TVALID. TDATA passes through bit-exact.
//
// Configuration macro:
//   RR_ARB_EN defined   : round-robin arbitration (1-bit pointer per lane);
//                         under contention the two inputs alternate.
//   RR_ARB_EN undefined : fixed priority; the lower-numbered input of a lane
//                         (Input_1, Input_3) always wins when both are valid.
//
// Ports:
//   ap_clk             in   clock, rising edge
//   ap_rst_n           in   synchronous active-low reset
//   ap_start           in   ignored (free-running block)
//   ap_done            out  constant 0
//   ap_idle            out  registered, 1 when both output slots are empty
//   ap_ready           out  constant 0
//   Input_k_V_TDATA    in   input k data  (k = 1..4)
//   Input_k_V_TVALID   in   input k valid
//   Input_k_V_TREADY   out  input k ready (depends combinationally on TVALID)
//   Output_j_V_TDATA   out  output j data (j = 1..2), registered
//   Output_j_V_TVALID  out  output j valid, registered
//   Output_j_V_TREADY  in   output j ready
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// t_merge_4to2_lane -- one arbiter plus one output slot.
//
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   lo_data/valid/ready    lower-numbered input of the lane
//   hi_data/valid/ready    higher-numbered input of the lane
//   out_data/valid/ready   lane output, driven straight from the slot
//   vld_next               next-state of the slot valid, used for ap_idle
// -----------------------------------------------------------------------------
module t_merge_4to2_lane #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] lo_data,
   input  logic                  lo_valid,
   output logic                  lo_ready,
   input  logic [DATA_WIDTH-1:0] hi_data,
   input  logic                  hi_valid,
   output logic                  hi_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  vld_next
);

   logic                  grant_lo;
   logic                  grant_hi;
   logic                  slot_free;
   logic                  take_lo;
   logic                  take_hi;
   logic                  slot_vld_p1;
   logic [DATA_WIDTH-1:0] slot_data_p1;

   // ---- stage p0: arbitration and input handshake ----
`ifdef RR_ARB_EN
   // prefer_hi = 1 means the higher-numbered input wins the next tie.
   // It flips toward the other input after every acceptance.
   logic prefer_hi;

   always_comb begin
      grant_lo = lo_valid & (~hi_valid | ~prefer_hi);
      grant_hi = hi_valid & (~lo_valid | prefer_hi);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prefer_hi <= 1'b0;
      end else if (take_lo) begin
         prefer_hi <= 1'b1;
      end else if (take_hi) begin
         prefer_hi <= 1'b0;
      end
   end
`else
   // Fixed priority: the lower-numbered input always wins a tie.
   always_comb begin
      grant_lo = lo_valid;
      grant_hi = hi_valid & ~lo_valid;
   end
`endif

   // The slot can take a beat when it is empty or is being drained this
   // cycle. Ready is forced low while reset is asserted so no upstream beat
   // is handshaken and then silently dropped by the reset.
   always_comb begin
      slot_free = ~slot_vld_p1 | out_ready;
      lo_ready  = grant_lo & slot_free & rst_n;
      hi_ready  = grant_hi & slot_free & rst_n;
      take_lo   = lo_valid & lo_ready;
      take_hi   = hi_valid & hi_ready;
   end

   // Next slot occupancy: a reload wins over a drain, which keeps the slot
   // full under simultaneous drain and accept.
   always_comb begin
      vld_next = slot_vld_p1;
      if (!rst_n) begin
         vld_next = 1'b0;
      end else if (take_lo | take_hi) begin
         vld_next = 1'b1;
      end else if (out_ready) begin
         vld_next = 1'b0;
      end
   end

   // ---- stage p1: registered output slot ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_vld_p1 <= 1'b0;
      end else begin
         slot_vld_p1 <= vld_next;
      end
   end

   // Data is cleared on reset so an idle output reads zero; otherwise it only
   // changes on acceptance, which keeps it stable while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_data_p1 <= '0;
      end else if (take_lo) begin
         slot_data_p1 <= lo_data;
      end else if (take_hi) begin
         slot_data_p1 <= hi_data;
      end
   end

   assign out_data  = slot_data_p1;
   assign out_valid = slot_vld_p1;

endmodule

// -----------------------------------------------------------------------------
// t_merge_4to2 -- top level: two independent lanes plus ap_* control.
// -----------------------------------------------------------------------------
module t_merge_4to2 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  ap_start,
   output logic                  ap_done,
   output logic                  ap_idle,
   output logic                  ap_ready,
   input  logic [DATA_WIDTH-1:0] Input_1_V_TDATA,
   input  logic                  Input_1_V_TVALID,
   output logic                  Input_1_V_TREADY,
   input  logic [DATA_WIDTH-1:0] Input_2_V_TDATA,
   input  logic                  Input_2_V_TVALID,
   output logic                  Input_2_V_TREADY,
   input  logic [DATA_WIDTH-1:0] Input_3_V_TDATA,
   input  logic                  Input_3_V_TVALID,
   output logic                  Input_3_V_TREADY,
   input  logic [DATA_WIDTH-1:0] Input_4_V_TDATA,
   input  logic                  Input_4_V_TVALID,
   output logic                  Input_4_V_TREADY,
   output logic [DATA_WIDTH-1:0] Output_1_V_TDATA,
   output logic                  Output_1_V_TVALID,
   input  logic                  Output_1_V_TREADY,
   output logic [DATA_WIDTH-1:0] Output_2_V_TDATA,
   output logic                  Output_2_V_TVALID,
   input  logic                  Output_2_V_TREADY
);

   logic vld_next_1;
   logic vld_next_2;
   logic idle_p1;
   logic unused_start;

   // The block is free-running; ap_start has no effect.
   assign unused_start = ap_start;
   assign ap_done      = 1'b0;
   assign ap_ready     = 1'b0;

   t_merge_4to2_lane #(
      .DATA_WIDTH(DATA_WIDTH)
   ) lane_1 (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .lo_data   (Input_1_V_TDATA),
      .lo_valid  (Input_1_V_TVALID),
      .lo_ready  (Input_1_V_TREADY),
      .hi_data   (Input_2_V_TDATA),
      .hi_valid  (Input_2_V_TVALID),
      .hi_ready  (Input_2_V_TREADY),
      .out_data  (Output_1_V_TDATA),
      .out_valid (Output_1_V_TVALID),
      .out_ready (Output_1_V_TREADY),
      .vld_next  (vld_next_1)
   );

   t_merge_4to2_lane #(
      .DATA_WIDTH(DATA_WIDTH)
   ) lane_2 (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .lo_data   (Input_3_V_TDATA),
      .lo_valid  (Input_3_V_TVALID),
      .lo_ready  (Input_3_V_TREADY),
      .hi_data   (Input_4_V_TDATA),
      .hi_valid  (Input_4_V_TVALID),
      .hi_ready  (Input_4_V_TREADY),
      .out_data  (Output_2_V_TDATA),
      .out_valid (Output_2_V_TVALID),
      .out_ready (Output_2_V_TREADY),
      .vld_next  (vld_next_2)
   );

   // ---- stage p1: idle flag ----
   // Registered from the slots' next state so it always equals
   // !vld_1 & !vld_2 of the current slot contents.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         idle_p1 <= 1'b1;
      end else begin
         idle_p1 <= ~vld_next_1 & ~vld_next_2;
      end
   end

   assign ap_idle = idle_p1;

endmodule
